fir_convolve_engine: RTL and testbench

- Parametrised successor to the single-accumulator audio convolver.
- Computes y[n] = sum over k of h[k]·x[n−k] for each incoming audio sample against an impulse response (IR) held in an external coefficient RAM.
- LANES taps are processed per clock from a banked internal history buffer.
- Sits between the audio sample source and the delayed-output stage; exposes busy/overrun status for the host FSM.

---
 rtl/conv_pkg.sv | 36 +++
 rtl/conv_history_banks.sv | 74 +++++++
 rtl/fir_convolve_engine.sv | 207 ++++++++++++++++++++
 tb/tb_fir_convolve_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the FIR convolution engine.
//   conv_state_t : control FSM states
//   PIPE_DEPTH   : cycles from coefficient address to accumulator update
//   MAX_ACC_W    : widest accumulator sat_trunc can handle
//   sat_trunc    : clamps a signed value to a signed range of a given width,
//                  used when FIR_CONVOLVE_SATURATE_EN is defined
package conv_pkg;

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    CONV,
    DRAIN,
    OUTPUT
  } conv_state_t;

  localparam int unsigned PIPE_DEPTH = 3;
  localparam int unsigned MAX_ACC_W  = 64;

  function automatic logic signed [MAX_ACC_W-1:0] sat_trunc(
    input logic signed [MAX_ACC_W-1:0] val,
    input int unsigned                 width
  );
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    hi = (MAX_ACC_W'(1) <<< (width - 1)) - MAX_ACC_W'(1);
    lo = -hi - MAX_ACC_W'(1);
    if (val > hi)
      sat_trunc = hi;
    else if (val < lo)
      sat_trunc = lo;
    else
      sat_trunc = val;
  endfunction

endpackage

// File: rtl/conv_history_banks.sv
// Banked sample history: LANES banks of G words each, one write port and
// one read per bank per cycle, so a whole group of LANES taps is read at once.
// Sample s lives in bank (s mod LANES) at word (s / LANES) mod G.
// Ports:
//   audio_clk          clock
//   wr_en/wr_grp/wr_lane/wr_data   single-sample write
//   clr_en/clr_grp     zero the same word in every bank (flush)
//   base_grp/base_lane position of the newest sample n
//   rd_grp             tap group g; lane j returns sample n - g*LANES - j
//   rd_data            packed lanes, 1-cycle registered read
module conv_history_banks
  import conv_pkg::*;
#(
  parameter  int unsigned SAMPLE_W = 16,
  parameter  int unsigned LANES    = 4,
  parameter  int unsigned G        = 1024,
  localparam int unsigned GW       = $clog2(G),
  localparam int unsigned LB       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                      audio_clk,
  input  logic                      wr_en,
  input  logic [GW-1:0]             wr_grp,
  input  logic [LB-1:0]             wr_lane,
  input  logic [SAMPLE_W-1:0]       wr_data,
  input  logic                      clr_en,
  input  logic [GW-1:0]             clr_grp,
  input  logic [GW-1:0]             base_grp,
  input  logic [LB-1:0]             base_lane,
  input  logic [GW-1:0]             rd_grp,
  output logic [LANES*SAMPLE_W-1:0] rd_data
);
  localparam int unsigned TW = GW + 2;

  logic [GW-1:0]       bank_ra [LANES];
  logic [SAMPLE_W-1:0] bank_q  [LANES];
  logic [LB-1:0]       rot_q;

  // Bank b serves the lane whose sample has low bits b. Banks above the
  // newest lane hold that lane's sample one word further back.
  always_comb begin
    logic [TW-1:0] tmp;
    tmp = '0;
    for (int unsigned b = 0; b < LANES; b++) begin
      tmp = TW'(base_grp) + TW'(G) - TW'(rd_grp);
      if (LB'(b) > base_lane)
        tmp = tmp - TW'(1);
      if (tmp >= TW'(G))
        tmp = tmp - TW'(G);
      bank_ra[b] = tmp[GW-1:0];
    end
  end

  for (genvar b = 0; b < LANES; b++) begin : g_bank
    logic [SAMPLE_W-1:0] mem [G];
    logic                we;
    assign we = clr_en | (wr_en & (wr_lane == LB'(b)));
    always_ff @(posedge audio_clk) begin
      if (we)
        mem[clr_en ? clr_grp : wr_grp] <= clr_en ? '0 : wr_data;
      bank_q[b] <= mem[bank_ra[b]];
    end
  end

  always_ff @(posedge audio_clk)
    rot_q <= base_lane;

  // Lane j comes from bank (n - j) mod LANES.
  always_comb begin
    rd_data = '0;
    for (int unsigned j = 0; j < LANES; j++)
      rd_data[j*SAMPLE_W +: SAMPLE_W] = bank_q[rot_q - LB'(j)];
  end

endmodule

// File: rtl/fir_convolve_engine.sv
// FIR convolution engine: y[n] = sum_k h[k]*x[n-k], LANES taps per clock,
// coefficients from an external RAM, history in internal banks.
// Optional build macro: FIR_CONVOLVE_SATURATE_EN clamps the shifted
// accumulator to the SAMPLE_W range; otherwise the low bits wrap.
// Ports:
//   audio_clk, rst_in (async, active high)
//   audio_trigger/audio_in   input sample strobe and data
//   ir_ready                 0 selects dry passthrough
//   ir_addr/ir_data          coefficient group address / packed coefs (1-cycle latency)
//   convolved_audio/out_valid result and its one-cycle strobe
//   busy                     state is not IDLE
//   overrun                  sticky: a queued sample was overwritten
module fir_convolve_engine
  import conv_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned TAPS      = 4096,
  parameter int unsigned LANES     = 4,
  parameter int unsigned ACC_W     = 48,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic                          audio_clk,
  input  logic                          rst_in,
  input  logic                          audio_trigger,
  input  logic signed [SAMPLE_W-1:0]    audio_in,
  input  logic                          ir_ready,
  output logic [$clog2(TAPS/LANES)-1:0] ir_addr,
  input  logic [LANES*COEF_W-1:0]       ir_data,
  output logic signed [SAMPLE_W-1:0]    convolved_audio,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun
);
  localparam int unsigned G  = TAPS / LANES;
  localparam int unsigned GW = $clog2(G);
  localparam int unsigned LB = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned PW = COEF_W + SAMPLE_W;
  localparam int unsigned DW = $clog2(PIPE_DEPTH + 1);

  conv_state_t state, state_nxt;

  logic [GW-1:0] flush_cnt;
  logic [GW-1:0] g;
  logic [DW-1:0] drain_cnt;
  logic [GW-1:0] wr_grp, cur_grp;
  logic [LB-1:0] wr_lane, cur_lane;

  logic                       pend_valid;
  logic signed [SAMPLE_W-1:0] pend_data;
  logic signed [SAMPLE_W-1:0] in_sample;
  logic                       have_sample, pend_take, trig_to_pend;
  logic                       accept_conv, accept_pass, out_load;

  logic [LANES*SAMPLE_W-1:0]  hist_rd;
  logic signed [COEF_W-1:0]   coef_l [LANES];
  logic signed [SAMPLE_W-1:0] hist_l [LANES];
  logic signed [PW-1:0]       prod   [LANES];
  logic                       rd_valid, prod_valid;
  logic signed [ACC_W-1:0]    tree_sum, acc;
  logic signed [SAMPLE_W-1:0] out_next;

  assign have_sample  = pend_valid | audio_trigger;
  assign in_sample    = pend_valid ? pend_data : audio_in;
  assign pend_take    = (state == IDLE) & pend_valid;
  assign trig_to_pend = audio_trigger & ((state != IDLE) | pend_valid);
  assign ir_addr      = g;
  assign busy         = (state != IDLE);

  always_ff @(posedge audio_clk or posedge rst_in)
    if (rst_in) state <= FLUSH;
    else        state <= state_nxt;

  always_comb begin
    state_nxt   = state;
    accept_conv = 1'b0;
    accept_pass = 1'b0;
    out_load    = 1'b0;
    case (state)
      FLUSH:  if (flush_cnt == GW'(G - 1)) state_nxt = IDLE;
      IDLE: begin
        if (have_sample) begin
          if (ir_ready) begin
            accept_conv = 1'b1;
            state_nxt   = CONV;
          end else begin
            accept_pass = 1'b1;
          end
        end
      end
      CONV:   if (g == GW'(G - 1)) state_nxt = DRAIN;
      DRAIN: begin
        if (drain_cnt == DW'(PIPE_DEPTH - 1)) begin
          state_nxt = OUTPUT;
          out_load  = 1'b1;
        end
      end
      OUTPUT: state_nxt = IDLE;
      default: state_nxt = FLUSH;
    endcase
  end

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      flush_cnt  <= '0;
      g          <= '0;
      drain_cnt  <= '0;
      wr_grp     <= '0;
      wr_lane    <= '0;
      cur_grp    <= '0;
      cur_lane   <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      overrun    <= 1'b0;
    end else begin
      flush_cnt <= (state == FLUSH) ? flush_cnt + GW'(1) : '0;
      g         <= (state == CONV)  ? g + GW'(1)         : '0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;

      if (accept_conv | accept_pass) begin
        cur_grp  <= wr_grp;
        cur_lane <= wr_lane;
        if (wr_lane == LB'(LANES - 1)) begin
          wr_lane <= '0;
          wr_grp  <= (wr_grp == GW'(G - 1)) ? '0 : wr_grp + GW'(1);
        end else begin
          wr_lane <= wr_lane + LB'(1);
        end
      end

      // A trigger arriving while the queued sample is still unused
      // replaces it; the older sample is lost.
      if (trig_to_pend) begin
        pend_data  <= audio_in;
        pend_valid <= 1'b1;
        if (pend_valid & ~pend_take)
          overrun <= 1'b1;
      end else if (pend_take) begin
        pend_valid <= 1'b0;
      end
    end
  end

  conv_history_banks #(
    .SAMPLE_W(SAMPLE_W),
    .LANES   (LANES),
    .G       (G)
  ) u_hist (
    .audio_clk(audio_clk),
    .wr_en    (accept_conv | accept_pass),
    .wr_grp   (wr_grp),
    .wr_lane  (wr_lane),
    .wr_data  (in_sample),
    .clr_en   (state == FLUSH),
    .clr_grp  (flush_cnt),
    .base_grp (cur_grp),
    .base_lane(cur_lane),
    .rd_grp   (g),
    .rd_data  (hist_rd)
  );

  always_comb begin
    for (int unsigned j = 0; j < LANES; j++) begin
      coef_l[j] = ir_data[j*COEF_W +: COEF_W];
      hist_l[j] = hist_rd[j*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_ff @(posedge audio_clk)
    for (int unsigned j = 0; j < LANES; j++)
      prod[j] <= PW'(coef_l[j]) * PW'(hist_l[j]);

  always_comb begin
    tree_sum = '0;
    for (int unsigned j = 0; j < LANES; j++)
      tree_sum = tree_sum + ACC_W'(prod[j]);
  end

`ifdef FIR_CONVOLVE_SATURATE_EN
  assign out_next = SAMPLE_W'(sat_trunc(MAX_ACC_W'(acc >>> OUT_SHIFT), SAMPLE_W));
`else
  assign out_next = SAMPLE_W'(acc >>> OUT_SHIFT);
`endif

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      rd_valid        <= 1'b0;
      prod_valid      <= 1'b0;
      acc             <= '0;
      out_valid       <= 1'b0;
      convolved_audio <= '0;
    end else begin
      rd_valid   <= (state == CONV);
      prod_valid <= rd_valid;
      if (accept_conv)
        acc <= '0;
      else if (prod_valid)
        acc <= acc + tree_sum;
      out_valid <= out_load | accept_pass;
      if (out_load)
        convolved_audio <= out_next;
      else if (accept_pass)
        convolved_audio <= in_sample;
    end
  end

endmodule

// File: tb/tb_fir_convolve_engine.sv
module tb_fir_convolve_engine;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned COEF_W    = 16;
  localparam int unsigned TAPS      = 16;
  localparam int unsigned LANES     = 4;
  localparam int unsigned ACC_W     = 48;
  localparam int unsigned OUT_SHIFT = 15;
  localparam int unsigned G         = TAPS / LANES;

  logic                       audio_clk = 1'b0;
  logic                       rst_in = 1'b1;
  logic                       audio_trigger = 1'b0;
  logic signed [SAMPLE_W-1:0] audio_in = '0;
  logic                       ir_ready = 1'b1;
  logic [$clog2(G)-1:0]       ir_addr;
  logic [LANES*COEF_W-1:0]    ir_data;
  logic signed [SAMPLE_W-1:0] convolved_audio;
  logic                       out_valid, busy, overrun;

  logic [COEF_W-1:0] h [TAPS];
  int n_checks = 0;
  int n_errors = 0;

  fir_convolve_engine #(
    .SAMPLE_W (SAMPLE_W),
    .COEF_W   (COEF_W),
    .TAPS     (TAPS),
    .LANES    (LANES),
    .ACC_W    (ACC_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .audio_clk      (audio_clk),
    .rst_in         (rst_in),
    .audio_trigger  (audio_trigger),
    .audio_in       (audio_in),
    .ir_ready       (ir_ready),
    .ir_addr        (ir_addr),
    .ir_data        (ir_data),
    .convolved_audio(convolved_audio),
    .out_valid      (out_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 audio_clk = ~audio_clk;

  function automatic logic [LANES*COEF_W-1:0] pack_group(input int grp);
    logic [LANES*COEF_W-1:0] w;
    w = '0;
    for (int j = 0; j < int'(LANES); j++)
      w[j*COEF_W +: COEF_W] = h[grp*LANES + j];
    return w;
  endfunction

  // Coefficient RAM model, one-cycle read latency.
  always @(posedge audio_clk)
    ir_data <= pack_group(int'(ir_addr));

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_identity();
    for (int k = 0; k < int'(TAPS); k++) h[k] = '0;
    h[0] = 16'h7FFF;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 60) begin
      @(negedge audio_clk);
      cycles++;
    end
    if (busy) cycles = -1;
  endtask

  task automatic fire(input logic signed [SAMPLE_W-1:0] v);
    @(negedge audio_clk);
    audio_trigger = 1'b1;
    audio_in      = v;
    @(negedge audio_clk);
    audio_trigger = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic signed [SAMPLE_W-1:0] val);
    lat = -1;
    val = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge audio_clk);
      if (out_valid) begin
        lat = k;
        val = convolved_audio;
        break;
      end
    end
  endtask

  task automatic run_one(input string tag, input logic signed [SAMPLE_W-1:0] v,
                         input int exp);
    int c, lat;
    logic signed [SAMPLE_W-1:0] val;
    wait_idle(c);
    fire(v);
    wait_out(lat, val);
    check_eq({tag, "_lat"}, lat, 7);
    check_eq({tag, "_val"}, val, exp);
  endtask

  task automatic do_reset();
    int c;
    @(negedge audio_clk);
    rst_in = 1'b1;
    @(negedge audio_clk);
    rst_in = 1'b0;
    wait_idle(c);
  endtask

  initial begin
    int c, pulses;
    int lat;
    logic signed [SAMPLE_W-1:0] val;
    int vals [2];
    int delay_exp [7];

    set_identity();
    repeat (2) @(negedge audio_clk);
    check_eq("rst_audio", convolved_audio, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_addr", ir_addr, 0);
    rst_in = 1'b0;
    wait_idle(c);
    check_eq("flush_cycles", c, 4);

    // Identity response, positive and negative inputs
    run_one("ident_pos", 16'sd1000, 999);
    run_one("ident_neg", -16'sd1000, -1000);

    // Dry passthrough
    ir_ready = 1'b0;
    wait_idle(c);
    fire(-16'sd1234);
    check_eq("pass_valid", out_valid, 1);
    check_eq("pass_val", convolved_audio, -1234);
    check_eq("pass_busy", busy, 0);
    @(negedge audio_clk);
    check_eq("pass_valid_drop", out_valid, 0);

    // ir_ready drops mid-CONV: result completes, next sample is dry
    ir_ready = 1'b1;
    wait_idle(c);
    fire(16'sd2000);
    ir_ready = 1'b0;
    wait_out(lat, val);
    check_eq("irdrop_lat", lat, 7);
    check_eq("irdrop_val", val, 1999);
    wait_idle(c);
    fire(16'sd321);
    check_eq("irdrop_pass_valid", out_valid, 1);
    check_eq("irdrop_pass_val", convolved_audio, 321);

    // Overrun: triggers on three consecutive cycles
    ir_ready = 1'b1;
    wait_idle(c);
    check_eq("ovr_before", overrun, 0);
    @(negedge audio_clk);
    audio_trigger = 1'b1; audio_in = 16'sd100;
    @(negedge audio_clk);
    audio_in = 16'sd200;
    @(negedge audio_clk);
    audio_in = 16'sd300;
    @(negedge audio_clk);
    audio_trigger = 1'b0;
    check_eq("ovr_busy", busy, 1);
    check_eq("ovr_flag", overrun, 1);
    pulses = 0;
    vals[0] = 0; vals[1] = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge audio_clk);
      if (out_valid) begin
        if (pulses < 2) vals[pulses] = int'(convolved_audio);
        pulses++;
      end
    end
    check_eq("ovr_pulses", pulses, 2);
    check_eq("ovr_first", vals[0], 99);
    check_eq("ovr_second", vals[1], 299);

    // Reset in the middle of CONV
    wait_idle(c);
    fire(16'sd500);
    @(negedge audio_clk);
    rst_in = 1'b1;
    @(negedge audio_clk);
    rst_in = 1'b0;
    check_eq("midrst_audio", convolved_audio, 0);
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_overrun", overrun, 0);
    check_eq("midrst_busy", busy, 1);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge audio_clk);
      if (k == 2) check_eq("midrst_flush_busy", busy, 1);
      if (k == 3) check_eq("midrst_flush_done", busy, 0);
      if (out_valid) pulses++;
    end
    check_eq("midrst_no_output", pulses, 0);
    run_one("midrst_ident", 16'sd1000, 999);

    // Pure delay of five taps at half gain, from a clean history
    do_reset();
    for (int k = 0; k < int'(TAPS); k++) h[k] = '0;
    h[5] = 16'h4000;
    delay_exp = '{0, 0, 0, 0, 0, 4000, 0};
    run_one("delay0", 16'sd8000, delay_exp[0]);
    for (int k = 1; k < 7; k++)
      run_one($sformatf("delay%0d", k), 16'sd0, delay_exp[k]);

    // Full-scale input against full-scale coefficients
    for (int k = 0; k < int'(TAPS); k++) h[k] = 16'h7FFF;
    for (int k = 0; k < 15; k++) begin
      wait_idle(c);
      fire(16'sd32767);
      wait_out(lat, val);
    end
`ifdef FIR_CONVOLVE_SATURATE_EN
    run_one("sat_last", 16'sd32767, 32767);
`else
    run_one("sat_last", 16'sd32767, -32);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
